// File: rtl/melody_sequencer_if.sv
// ----------------------------------------------------------------------------
// melody_sequencer_if
// Bundles the keypad-side inputs and decoder-side outputs of the melody
// sequencer. Clock and reset stay outside the bundle.
//   key_valid_i / key_value_i : new scanned key press and its 4-bit code
//   rec_i / loop_i            : record-mode and loop-playback levels
//   play_i / stop_i           : playback start and abort strobes
//   key_value_o / tone_en_o   : note code to the decoder and tone enable
//   busy_o / full_o / count_o : playback active, buffer full, notes stored
// Modports: master drives the inputs (scanner/controller side), slave is the
// sequencer itself.
// ----------------------------------------------------------------------------
interface melody_sequencer_if #(
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          key_valid_i;
    logic [3:0]    key_value_i;
    logic          rec_i;
    logic          play_i;
    logic          loop_i;
    logic          stop_i;
    logic [3:0]    key_value_o;
    logic          tone_en_o;
    logic          busy_o;
    logic          full_o;
    logic [CW-1:0] count_o;

    modport master (
        output key_valid_i, key_value_i, rec_i, play_i, loop_i, stop_i,
        input  key_value_o, tone_en_o, busy_o, full_o, count_o
    );

    modport slave (
        input  key_valid_i, key_value_i, rec_i, play_i, loop_i, stop_i,
        output key_value_o, tone_en_o, busy_o, full_o, count_o
    );
endinterface

// File: rtl/melody_sequencer.sv
// ----------------------------------------------------------------------------
// melody_sequencer
// Records keypad note codes (1..C) into a DEPTH-entry buffer and plays them
// back, each note sounding NOTE_TICKS cycles followed by GAP_TICKS of silence.
// Ports:
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset
//   bus    : melody_sequencer_if.slave (key input, mode controls, outputs)
// All outputs are registered.
// ----------------------------------------------------------------------------
module melody_sequencer #(
    parameter int DEPTH      = 16,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    melody_sequencer_if.slave   bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXT = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TW   = $clog2(MAXT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REC  = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [3:0]    mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    key_value_q, key_value_d;
    logic          tone_en_q, tone_en_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;

    logic          wr_en;
    logic          load_note;
    logic          code_ok;

    assign code_ok = (bus.key_value_i >= 4'h1) && (bus.key_value_i <= 4'hC);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_idx_d    = rd_idx_q;
        timer_d     = timer_q;
        key_value_d = key_value_q;
        tone_en_d   = tone_en_q;
        wr_en       = 1'b0;
        load_note   = 1'b0;

        case (state_q)
            S_IDLE: begin
                key_value_d = 4'h0;
                tone_en_d   = 1'b0;
                if (bus.rec_i) begin
                    state_d = S_REC;
                    count_d = '0;
                end else if (bus.play_i && (count_q != '0)) begin
                    state_d   = S_PLAY;
                    rd_idx_d  = '0;
                    timer_d   = '0;
                    load_note = 1'b1;
                end
            end
            S_REC: begin
                // A press in the same cycle rec_i drops is still captured.
                if (bus.key_valid_i && code_ok && (count_q < CW'(DEPTH))) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                end
                if (!bus.rec_i) begin
                    state_d = S_IDLE;
                end
            end
            S_PLAY: begin
                if (bus.stop_i) begin
                    state_d     = S_IDLE;
                    key_value_d = 4'h0;
                    tone_en_d   = 1'b0;
                    timer_d     = '0;
                end else if (timer_q == TW'(NOTE_TICKS - 1)) begin
                    state_d   = S_GAP;
                    timer_d   = '0;
                    tone_en_d = 1'b0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin // S_GAP
                if (bus.stop_i) begin
                    state_d     = S_IDLE;
                    key_value_d = 4'h0;
                    tone_en_d   = 1'b0;
                    timer_d     = '0;
                end else if (timer_q == TW'(GAP_TICKS - 1)) begin
                    timer_d = '0;
                    if (CW'(rd_idx_q) < (count_q - 1'b1)) begin
                        state_d   = S_PLAY;
                        rd_idx_d  = rd_idx_q + 1'b1;
                        load_note = 1'b1;
                    end else if (bus.loop_i) begin
                        state_d   = S_PLAY;
                        rd_idx_d  = '0;
                        load_note = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        key_value_d = 4'h0;
                        tone_en_d   = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        endcase

        // The note register is loaded on entry to PLAY so the code and the
        // tone enable appear on the same edge.
        if (load_note) begin
            key_value_d = mem[rd_idx_d];
            tone_en_d   = 1'b1;
        end

        busy_d = (state_d == S_PLAY) || (state_d == S_GAP);
        full_d = (count_d == CW'(DEPTH));
    end

    // Note buffer: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[count_q[AW-1:0]] <= bus.key_value_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rd_idx_q    <= '0;
            timer_q     <= '0;
            key_value_q <= 4'h0;
            tone_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            full_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_idx_q    <= rd_idx_d;
            timer_q     <= timer_d;
            key_value_q <= key_value_d;
            tone_en_q   <= tone_en_d;
            busy_q      <= busy_d;
            full_q      <= full_d;
        end
    end

    assign bus.key_value_o = key_value_q;
    assign bus.tone_en_o   = tone_en_q;
    assign bus.busy_o      = busy_q;
    assign bus.full_o      = full_q;
    assign bus.count_o     = count_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// ----------------------------------------------------------------------------
// tb_melody_sequencer
// Directed bench for melody_sequencer with DEPTH=4, NOTE_TICKS=4, GAP_TICKS=2.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_melody_sequencer;
    localparam int DEPTH      = 4;
    localparam int NOTE_TICKS = 4;
    localparam int GAP_TICKS  = 2;
    localparam int PERIOD     = NOTE_TICKS + GAP_TICKS;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [3:0] exp_notes [3];

    melody_sequencer_if #(.DEPTH(DEPTH)) bus ();

    melody_sequencer #(
        .DEPTH      (DEPTH),
        .NOTE_TICKS (NOTE_TICKS),
        .GAP_TICKS  (GAP_TICKS)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_value_i = code;
        bus.key_valid_i = 1'b1;
        tick();
        bus.key_valid_i = 1'b0;
        $display("press %0h -> count %0d full %0b", code, bus.count_o, bus.full_o);
    endtask

    task automatic start_play();
        bus.play_i = 1'b1;
        tick();
        bus.play_i = 1'b0;
        $display("play -> tone %0b key %0h busy %0b", bus.tone_en_o, bus.key_value_o, bus.busy_o);
    endtask

    // Checks one full pass over exp_notes, starting right after the play edge.
    task automatic check_pass(input string tag);
        for (int i = 0; i < 3 * PERIOD; i++) begin
            check({tag, "_tone"}, 32'(bus.tone_en_o), 32'((i % PERIOD) < NOTE_TICKS));
            check({tag, "_key"},  32'(bus.key_value_o), 32'(exp_notes[i / PERIOD]));
            check({tag, "_busy"}, 32'(bus.busy_o), 32'd1);
            tick();
        end
    endtask

    initial begin
        exp_notes[0] = 4'h1;
        exp_notes[1] = 4'h3;
        exp_notes[2] = 4'h8;
        bus.key_valid_i = 1'b0;
        bus.key_value_i = 4'h0;
        bus.rec_i       = 1'b0;
        bus.play_i      = 1'b0;
        bus.loop_i      = 1'b0;
        bus.stop_i      = 1'b0;

        // 1. Reset values
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        check("rst_key",   32'(bus.key_value_o), 32'd0);
        check("rst_tone",  32'(bus.tone_en_o), 32'd0);
        check("rst_busy",  32'(bus.busy_o), 32'd0);
        check("rst_full",  32'(bus.full_o), 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);

        // 2. Record 1,3,0,F,8 -> only valid codes kept
        bus.rec_i = 1'b1;
        tick();
        press(4'h1);
        check("rec_cnt1", 32'(bus.count_o), 32'd1);
        press(4'h3);
        check("rec_cnt2", 32'(bus.count_o), 32'd2);
        press(4'h0);
        press(4'hF);
        check("rec_drop", 32'(bus.count_o), 32'd2);
        press(4'h8);
        check("rec_cnt3", 32'(bus.count_o), 32'd3);
        check("rec_nfull", 32'(bus.full_o), 32'd0);
        bus.rec_i = 1'b0;
        tick();

        // 4. Single pass playback: tone 1111_00 x3, then idle
        start_play();
        check_pass("pass");
        check("end_busy", 32'(bus.busy_o), 32'd0);
        check("end_tone", 32'(bus.tone_en_o), 32'd0);
        check("end_key",  32'(bus.key_value_o), 32'd0);

        // 5. Looping playback, then stop mid-note
        bus.loop_i = 1'b1;
        start_play();
        check_pass("loop");
        check("loop_key",  32'(bus.key_value_o), 32'd1);
        check("loop_tone", 32'(bus.tone_en_o), 32'd1);
        tick();
        tick();
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;
        bus.loop_i = 1'b0;
        $display("stop -> tone %0b busy %0b count %0d", bus.tone_en_o, bus.busy_o, bus.count_o);
        check("stop_tone",  32'(bus.tone_en_o), 32'd0);
        check("stop_busy",  32'(bus.busy_o), 32'd0);
        check("stop_key",   32'(bus.key_value_o), 32'd0);
        check("stop_count", 32'(bus.count_o), 32'd3);

        // 3. Fill the buffer: six presses, last two dropped
        bus.rec_i = 1'b1;
        tick();
        check("fill_clear", 32'(bus.count_o), 32'd0);
        for (int i = 0; i < 6; i++) begin
            press(4'(i + 1));
            check("fill_cnt", 32'(bus.count_o), 32'((i + 1 < DEPTH) ? i + 1 : DEPTH));
        end
        check("fill_full", 32'(bus.full_o), 32'd1);
        bus.rec_i = 1'b0;
        tick();

        // Press on the same edge rec_i falls is stored
        bus.rec_i = 1'b1;
        tick();
        check("fall_clear", 32'(bus.full_o), 32'd0);
        bus.rec_i       = 1'b0;
        bus.key_value_i = 4'h5;
        bus.key_valid_i = 1'b1;
        tick();
        bus.key_valid_i = 1'b0;
        $display("press 5 with rec falling -> count %0d", bus.count_o);
        check("fall_cnt", 32'(bus.count_o), 32'd1);
        start_play();
        check("fall_key",  32'(bus.key_value_o), 32'd5);
        check("fall_tone", 32'(bus.tone_en_o), 32'd1);
        bus.stop_i = 1'b1;
        tick();
        bus.stop_i = 1'b0;

        // 6. play_i with an empty buffer stays idle
        bus.rec_i = 1'b1;
        tick();
        bus.rec_i = 1'b0;
        tick();
        check("empty_cnt", 32'(bus.count_o), 32'd0);
        start_play();
        check("empty_busy", 32'(bus.busy_o), 32'd0);
        check("empty_tone", 32'(bus.tone_en_o), 32'd0);

        // Asynchronous reset during GAP
        bus.rec_i = 1'b1;
        tick();
        press(4'h2);
        press(4'h4);
        bus.rec_i = 1'b0;
        tick();
        start_play();
        for (int i = 0; i < NOTE_TICKS; i++) tick();
        check("gap_tone", 32'(bus.tone_en_o), 32'd0);
        check("gap_busy", 32'(bus.busy_o), 32'd1);
        check("gap_key",  32'(bus.key_value_o), 32'd2);
        #2;
        rst_i = 1'b1;
        #1;
        $display("async reset in gap -> busy %0b count %0d", bus.busy_o, bus.count_o);
        check("arst_busy",  32'(bus.busy_o), 32'd0);
        check("arst_key",   32'(bus.key_value_o), 32'd0);
        check("arst_tone",  32'(bus.tone_en_o), 32'd0);
        check("arst_count", 32'(bus.count_o), 32'd0);
        tick();
        rst_i = 1'b0;
        tick();
        check("arst_idle", 32'(bus.busy_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end
endmodule
